inst_encoder: RTL and testbench

- Instruction encoder: takes a format code, register fields, funct fields and a 32-bit signed immediate, and packs them into one RV32I instruction word.
- Performs the inverse of the core's Sign_Extend immediate generator. Sign_Extend applied to Inst_o must return Imm_i for every accepted non-R instruction.
- Sits between the test/boot loader and instruction-memory write port. Provides valid/ready handshake, immediate range checking and a word-address counter.

---
 rtl/inst_encoder.sv | 84 ++++++++
 tb/tb_inst_encoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs format code, register/funct fields and a signed immediate into an RV32I word
// Ports:
//   Clk_i, Rst_i        rising-edge clock, asynchronous active-high reset
//   Valid_i / Ready_o   request handshake (Fmt_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Funct7_i, Imm_i)
//   Valid_o / Ready_i   output handshake (Inst_o, Addr_o)
//   Err_o               one-cycle pulse after an illegal request was consumed
//   Count_o             deliveries since reset, saturating at 0xFFFF
module inst_encoder #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic              Valid_i,
    output logic              Ready_o,
    input  logic [2:0]        Fmt_i,
    input  logic [4:0]        Rd_i,
    input  logic [4:0]        Rs1_i,
    input  logic [4:0]        Rs2_i,
    input  logic [2:0]        Funct3_i,
    input  logic [6:0]        Funct7_i,
    input  logic [31:0]       Imm_i,
    output logic              Valid_o,
    input  logic              Ready_i,
    output logic [31:0]       Inst_o,
    output logic [ADDR_W-1:0] Addr_o,
    output logic              Err_o,
    output logic [15:0]       Count_o
);
    logic signed [31:0] imm;
    logic               accept, deliver, legal, fit12, fit13, fit21;
    logic [31:0]        enc;

    assign imm     = Imm_i;
    assign Ready_o = !Valid_o || Ready_i;
    assign accept  = Valid_i && Ready_o;
    assign deliver = Valid_o && Ready_i;
    assign fit12   = imm >= -2048 && imm <= 2047;
    assign fit13   = imm >= -4096 && imm <= 4094;
    assign fit21   = imm >= -1048576 && imm <= 1048574;
    // branch and jump offsets are in halfword units, so bit 0 must be clear
    assign legal   = Fmt_i == 3'd7 ? 1'b0 :
                     Fmt_i == 3'd0 ? 1'b1 :
                     Fmt_i == 3'd5 ? fit13 && !Imm_i[0] :
                     Fmt_i == 3'd6 ? fit21 && !Imm_i[0] : fit12;

    always_comb begin
        enc = '0;
        case (Fmt_i)
            3'd0: enc = {Funct7_i, Rs2_i, Rs1_i, Funct3_i, Rd_i, 7'b0110011};
            3'd1: enc = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, 7'b0000011};
            3'd2: enc = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, 7'b0010011};
            3'd3: enc = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, 7'b1100111};
            3'd4: enc = {Imm_i[11:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:0], 7'b0100011};
            3'd5: enc = {Imm_i[12], Imm_i[10:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:1], Imm_i[11], 7'b1100011};
            3'd6: enc = {Imm_i[20], Imm_i[10:1], Imm_i[11], Imm_i[19:12], Rd_i, 7'b1101111};
            default: enc = '0;
        endcase
    end

    // Addr_o advances on every delivery, so a word accepted alongside a
    // delivery already picks up the incremented address.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            Valid_o <= 1'b0;
            Inst_o  <= '0;
            Addr_o  <= BASE_ADDR;
            Err_o   <= 1'b0;
            Count_o <= '0;
        end else begin
            Err_o <= accept && !legal;
            if (accept && legal) begin
                Valid_o <= 1'b1;
                Inst_o  <= enc;
            end else if (deliver) begin
                Valid_o <= 1'b0;
            end
            if (deliver) begin
                Addr_o <= Addr_o + ADDR_W'(4);
                if (Count_o != 16'hFFFF) Count_o <= Count_o + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed checks of inst_encoder against a transaction-level model
module tb_inst_encoder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 0, ready_i = 0, b_valid_i = 0, b_ready_i = 0;
    logic [2:0]  fmt = 0, f3 = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic [6:0]  f7 = 0;
    logic [31:0] imm = 0;
    logic        ready_o, valid_o, err_o, b_ready_o, b_valid_o, b_err_o;
    logic [31:0] inst_o, addr_o, b_inst_o;
    logic [3:0]  b_addr_o;
    logic [15:0] count_o, b_count_o;

    always #5 clk = ~clk;

    inst_encoder dut (
        .Clk_i(clk), .Rst_i(rst), .Valid_i(valid_i), .Ready_o(ready_o), .Fmt_i(fmt),
        .Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2), .Funct3_i(f3), .Funct7_i(f7), .Imm_i(imm),
        .Valid_o(valid_o), .Ready_i(ready_i), .Inst_o(inst_o), .Addr_o(addr_o),
        .Err_o(err_o), .Count_o(count_o)
    );

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_b (
        .Clk_i(clk), .Rst_i(rst), .Valid_i(b_valid_i), .Ready_o(b_ready_o), .Fmt_i(fmt),
        .Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2), .Funct3_i(f3), .Funct7_i(f7), .Imm_i(imm),
        .Valid_o(b_valid_o), .Ready_i(b_ready_i), .Inst_o(b_inst_o), .Addr_o(b_addr_o),
        .Err_o(b_err_o), .Count_o(b_count_o)
    );

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // model state: the word currently presented and how many words were delivered
    bit          m_valid, m_err;
    logic [31:0] m_inst, m_imm, m_addr;
    int          m_fmt, ndel;

    function automatic bit legal(input int f, input int im);
        case (f)
            0: return 1;
            1, 2, 3, 4: return im >= -2048 && im <= 2047;
            5: return im >= -4096 && im <= 4094 && (im & 1) == 0;
            6: return im >= -1048576 && im <= 1048574 && (im & 1) == 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input int f, input logic [31:0] d, s1, s2, fn3, fn7, u);
        logic [31:0] ops [7] = '{32'd51, 32'd3, 32'd19, 32'd103, 32'd35, 32'd99, 32'd111};
        logic [31:0] op = ops[f];
        case (f)
            0: return op | d << 7 | fn3 << 12 | s1 << 15 | s2 << 20 | fn7 << 25;
            1, 2, 3: return op | d << 7 | fn3 << 12 | s1 << 15 | (u & 32'hFFF) << 20;
            4: return op | (u & 31) << 7 | fn3 << 12 | s1 << 15 | s2 << 20 | ((u >> 5) & 127) << 25;
            5: return op | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | fn3 << 12 | s1 << 15
                      | s2 << 20 | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
            default: return op | d << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20
                      | ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
        endcase
    endfunction

    // the core's immediate generator: recovers the immediate from an encoded word
    function automatic logic [31:0] sext(input int f, input logic [31:0] i);
        case (f)
            4: return {{20{i[31]}}, i[31:25], i[11:7]};
            5: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            6: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic sample();
        @(negedge clk);
        check("valid", valid_o, m_valid);
        check("err", err_o, m_err);
        check("count", count_o, ndel > 65535 ? 65535 : ndel);
        if (m_valid) begin
            check("inst", inst_o, m_inst);
            check("addr", addr_o, m_addr);
            if (m_fmt != 0) check("sext", sext(m_fmt, inst_o), m_imm);
        end
    endtask

    task automatic drive(input bit v, r, input int f, d, s1, s2, fn3, fn7, input logic [31:0] u);
        bit acc, del, ok;
        valid_i = v; ready_i = r; fmt = 3'(f); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
        f3 = 3'(fn3); f7 = 7'(fn7); imm = u;
        #1 check("ready", ready_o, !m_valid || r);
        acc = v && (!m_valid || r);
        del = m_valid && r;
        ok  = legal(f, u);
        if (del) ndel++;
        m_err = acc && !ok;
        if (acc && ok) begin
            m_valid = 1;
            m_fmt   = f;
            m_imm   = u;
            m_inst  = enc(f, rd, rs1, rs2, f3, f7, u);
            m_addr  = 32'(4 * ndel);
        end else if (del) m_valid = 0;
    endtask

    task automatic step(input bit v, r, input int f, d, s1, s2, fn3, fn7, input logic [31:0] u);
        sample();
        drive(v, r, f, d, s1, s2, fn3, fn7, u);
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_count", count_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_err", err_o, 0);
        check("rst_b_addr", b_addr_o, 4'hC);
        m_valid = 0; m_err = 0; ndel = 0;
        valid_i = 0; b_valid_i = 0;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    logic [31:0] bounds [16] = '{2047, -2048, 2048, -2049, 4094, 4095, -4096, -4098,
                                 1048574, -1048576, 1048575, 1048576, -1048578, 0, 1, -1};

    initial begin
        logic [31:0] u, hold_inst, hold_addr;
        #12;
        check("init_valid", valid_o, 0);
        check("init_addr", addr_o, 0);
        check("init_count", count_o, 0);
        @(negedge clk);
        rst = 0;
        #1;
        // addi x1, x0, 5
        step(1, 1, 2, 1, 0, 0, 0, 0, 5);
        sample();
        check("tp_addi", inst_o, 32'h00500093);
        check("tp_addi_addr", addr_o, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        // sw then beq back-to-back
        step(1, 1, 4, 0, 1, 2, 2, 0, 8);
        sample();
        check("tp_sw", inst_o, 32'h0020A423);
        check("tp_sw_addr", addr_o, 0);
        drive(1, 1, 5, 0, 1, 2, 0, 0, -8);
        sample();
        check("tp_beq", inst_o, 32'hFE208CE3);
        check("tp_beq_addr", addr_o, 4);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("tp_count2", count_o, 2);
        // jal x1, 2048
        drive(1, 1, 6, 1, 0, 0, 0, 0, 2048);
        sample();
        check("tp_jal", inst_o, 32'h001000EF);
        check("tp_jal_sext", sext(6, inst_o), 32'h800);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // illegal requests
        step(1, 1, 5, 0, 1, 2, 0, 0, 5);
        sample();
        check("tp_err_odd", err_o, 1);
        drive(1, 1, 2, 1, 0, 0, 0, 0, 2048);
        sample();
        check("tp_err_range", err_o, 1);
        check("tp_err_count", count_o, 3);
        check("tp_err_addr", addr_o, 12);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // stall: new request held off until downstream is ready
        step(1, 0, 2, 3, 4, 0, 1, 0, 100);
        sample();
        hold_inst = inst_o; hold_addr = addr_o;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 2, 5, 6, 0, 0, 0, 7);
            check("tp_stall_ready", ready_o, 0);
            sample();
            check("tp_stall_inst", inst_o, hold_inst);
            check("tp_stall_addr", addr_o, hold_addr);
        end
        drive(1, 1, 2, 5, 6, 0, 0, 0, 7);
        sample();
        check("tp_stall_adv", addr_o, hold_addr + 4);
        drive(1, 0, 1, 2, 3, 0, 2, 0, -4);
        sample();
        // reset mid-stall
        do_reset();
        // narrow address counter wraps
        b_valid_i = 1; b_ready_i = 1;
        drive(0, 1, 2, 1, 0, 0, 0, 0, 5);
        sample();
        check("b_valid", b_valid_o, 1);
        check("b_addr0", b_addr_o, 4'hC);
        drive(0, 1, 2, 1, 0, 0, 0, 0, 5);
        sample();
        check("b_addr1", b_addr_o, 4'h0);
        b_valid_i = 0;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 6)
                0: u = 32'($urandom_range(0, 127)) - 64;
                1: u = bounds[$urandom % 16];
                2: u = $urandom;
                3: u = 32'($urandom_range(0, 8191)) - 4096;
                4: u = 32'($urandom_range(0, 2097151)) - 1048576;
                default: u = 32'($urandom_range(0, 4095)) - 2048;
            endcase
            if (n == 1500) begin
                sample();
                do_reset();
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            step($urandom % 4 != 0, $urandom % 4 != 0, $urandom % 8, $urandom % 32,
                 $urandom % 32, $urandom % 32, $urandom % 8, $urandom % 128, u);
        end
        sample();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
